// File: rtl/rainbow_pkg.sv
// Shared constants, hue colour table and helpers for the rainbow breathing LED driver.
package rainbow_pkg;

  localparam int HUE_COUNT = 6;

  // Breathing direction of the shared brightness envelope.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // RGB on-mask for a hue index, bit 2 = red, bit 1 = green, bit 0 = blue.
  function automatic logic [2:0] hue_mask(input int unsigned idx);
    logic [2:0] mask;
    case (idx)
      0:       mask = 3'b100;
      1:       mask = 3'b110;
      2:       mask = 3'b010;
      3:       mask = 3'b011;
      4:       mask = 3'b001;
      5:       mask = 3'b101;
      default: mask = 3'b000;
    endcase
    return mask;
  endfunction

  // Bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rainbow_breathing_pwm_multi_btn_debounce.sv
// One button bit: 2-FF synchroniser, stability counter, one-cycle pulse on a
// debounced rising edge.
module btn_debounce
  import rainbow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Synchronise, count consecutive disagreeing cycles, accept the new level
  // once it has persisted long enough and flag a rising edge for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable <= sync2;
          cnt    <= '0;
          pulse  <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/rainbow_breathing_pwm_multi.sv
// Multi-channel rainbow breathing PWM: shared envelope, per-channel hue offset,
// debounced speed buttons with one-hot speed display.
module rainbow_breathing_pwm_multi
  import rainbow_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int PWM_BITS        = 8,
  parameter int NUM_SPEEDS      = 4,
  parameter int RESET_SPEED     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WRAP            = 0,
  parameter int HUE_OFFSET      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            btn,
  output logic [NUM_SPEEDS-1:0] led_mode,
  output logic [NUM_CH-1:0]     led_r,
  output logic [NUM_CH-1:0]     led_g,
  output logic [NUM_CH-1:0]     led_b
);

  localparam int LW = (NUM_SPEEDS > 1) ? clog2(NUM_SPEEDS) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic                  up_pulse;
  logic                  dn_pulse;
  logic [LW-1:0]         level;
  logic [LW-1:0]         level_nxt;
  logic                  level_chg;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [PWM_BITS-1:0]   brightness;
  dir_t                  dir;
  logic [2:0]            hue;
  logic [NUM_SPEEDS-1:0] step_cnt;
  logic [NUM_SPEEDS-1:0] step_max;
  logic                  tick;
  logic                  pwm_on;
  logic [NUM_CH-1:0]     r_nxt;
  logic [NUM_CH-1:0]     g_nxt;
  logic [NUM_CH-1:0]     b_nxt;
  int unsigned           idx;
  logic [2:0]            mask;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn[0]),
    .pulse (up_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn[1]),
    .pulse (dn_pulse)
  );

  // Next speed level from the button pulses; simultaneous pulses cancel.
  always_comb begin
    level_nxt = level;
    if (up_pulse && !dn_pulse) begin
      if (level == LW'(NUM_SPEEDS - 1)) level_nxt = (WRAP != 0) ? '0 : level;
      else                              level_nxt = level + 1'b1;
    end else if (dn_pulse && !up_pulse) begin
      if (level == '0) level_nxt = (WRAP != 0) ? LW'(NUM_SPEEDS - 1) : level;
      else             level_nxt = level - 1'b1;
    end
  end

  assign level_chg = (level_nxt != level);
  assign led_mode  = NUM_SPEEDS'(1) << level;
  assign tick      = (pwm_cnt == PWM_MAX);
  assign pwm_on    = (pwm_cnt < brightness);

  // Periods per brightness step: slower levels wait exponentially longer.
  always_comb begin
    step_max = NUM_SPEEDS'((1 << (NUM_SPEEDS - 1 - int'(level))) - 1);
  end

  // Speed level, PWM counter and step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level    <= LW'(RESET_SPEED);
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      level   <= level_nxt;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (level_chg) begin
        step_cnt <= '0;
      end else if (tick) begin
        step_cnt <= (step_cnt == step_max) ? '0 : step_cnt + 1'b1;
      end
    end
  end

  // Triangle envelope: the step that reaches an end holds the value and
  // flips direction; completing a full breath advances the hue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      brightness <= '0;
      dir        <= DIR_UP;
      hue        <= '0;
    end else if (!level_chg && tick && (step_cnt == step_max)) begin
      if (dir == DIR_UP) begin
        if (brightness == PWM_MAX) dir <= DIR_DOWN;
        else                       brightness <= brightness + 1'b1;
      end else begin
        if (brightness == '0) begin
          dir <= DIR_UP;
          hue <= (hue == 3'(HUE_COUNT - 1)) ? 3'd0 : hue + 3'd1;
        end else begin
          brightness <= brightness - 1'b1;
        end
      end
    end
  end

  // Per-channel colour: hue rotated by the channel offset, gated by the PWM compare.
  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    idx   = 0;
    mask  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      idx      = (int'(hue) + c * HUE_OFFSET) % HUE_COUNT;
      mask     = hue_mask(idx);
      r_nxt[c] = mask[2] & pwm_on;
      g_nxt[c] = mask[1] & pwm_on;
      b_nxt[c] = mask[0] & pwm_on;
    end
  end

  // Registered LED pins, one clock behind the PWM counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_r <= '0;
      led_g <= '0;
      led_b <= '0;
    end else begin
      led_r <= r_nxt;
      led_g <= g_nxt;
      led_b <= b_nxt;
    end
  end

endmodule

// File: tb/tb_rainbow_breathing_pwm_multi.sv
// Bench: three instances (3-channel main, WRAP=1, small 3-bit PWM) against a
// step-count based envelope model plus hand-built corner sequences.
module tb_rainbow_breathing_pwm_multi;

  localparam int DB = 4;

  // ---------------- clock / reset / DUTs ----------------
  logic       clk;
  logic       rst_n;
  logic [1:0] btn;
  logic [1:0] btn_s;
  logic [3:0] mode_m, mode_w;
  logic [2:0] r_m, g_m, b_m;
  logic [1:0] r_w, g_w, b_w;
  logic [1:0] mode_s, r_s, g_s, b_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rainbow_breathing_pwm_multi #(.NUM_CH(3), .HUE_OFFSET(2)) dut_main (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .led_mode(mode_m), .led_r(r_m), .led_g(g_m), .led_b(b_m)
  );

  rainbow_breathing_pwm_multi #(.WRAP(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .led_mode(mode_w), .led_r(r_w), .led_g(g_w), .led_b(b_w)
  );

  rainbow_breathing_pwm_multi #(.PWM_BITS(3), .NUM_SPEEDS(2), .RESET_SPEED(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .btn(btn_s),
    .led_mode(mode_s), .led_r(r_s), .led_g(g_s), .led_b(b_s)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0 = main, 1 = small) ----------------
  int         p_bits [2] = '{8, 3};
  int         n_spd  [2] = '{4, 2};
  int         r_spd  [2] = '{2, 1};
  int         n_ch   [2] = '{3, 2};
  logic [2:0] hue_tab [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  int         m_t [2];
  int         m_steps [2];
  int         m_ticks [2];
  int         m_level [2];
  logic       m_stab [2][2];
  logic       m_pend [2][2];
  logic [7:0] m_hist [2][2];
  logic [3:0] e_mode [2];
  logic [2:0] e_r [2];
  logic [2:0] e_g [2];
  logic [2:0] e_b [2];

  // Brightness after a number of envelope steps: a triangle of period 2*max+2
  // with the end values held for one step.
  function automatic int tri_val(input int steps, input int mx);
    int p;
    p = steps % (2 * mx + 2);
    return (p <= mx) ? p : 2 * mx + 1 - p;
  endfunction

  task automatic model_step(input int i, input logic [1:0] bi, input logic rst);
    int   per, mx, pwm, b, hue, nl;
    logic up, dn;
    logic [DB-1:0] win;
    if (!rst) begin
      m_t[i] = 0; m_steps[i] = 0; m_ticks[i] = 0; m_level[i] = r_spd[i];
      for (int k = 0; k < 2; k++) begin
        m_stab[i][k] = 1'b0; m_pend[i][k] = 1'b0; m_hist[i][k] = '0;
      end
      e_r[i] = '0; e_g[i] = '0; e_b[i] = '0;
      e_mode[i] = 4'(1 << r_spd[i]);
      return;
    end
    per = 1 << p_bits[i];
    mx  = per - 1;
    pwm = m_t[i] % per;
    b   = tri_val(m_steps[i], mx);
    hue = (m_steps[i] / (2 * mx + 2)) % 6;
    e_r[i] = '0; e_g[i] = '0; e_b[i] = '0;
    for (int c = 0; c < n_ch[i]; c++) begin
      e_r[i][c] = hue_tab[(hue + 2 * c) % 6][2] && (pwm < b);
      e_g[i][c] = hue_tab[(hue + 2 * c) % 6][1] && (pwm < b);
      e_b[i][c] = hue_tab[(hue + 2 * c) % 6][0] && (pwm < b);
    end
    // speed change from pulses registered on the previous edge (saturating)
    up = m_pend[i][0];
    dn = m_pend[i][1];
    nl = m_level[i];
    if (up && !dn) nl = (m_level[i] == n_spd[i] - 1) ? m_level[i] : m_level[i] + 1;
    if (dn && !up) nl = (m_level[i] == 0) ? 0 : m_level[i] - 1;
    if (nl != m_level[i]) begin
      m_level[i] = nl;
      m_ticks[i] = 0;
    end else if (pwm == mx) begin
      m_ticks[i]++;
      if (m_ticks[i] == (1 << (n_spd[i] - 1 - m_level[i]))) begin
        m_ticks[i] = 0;
        m_steps[i]++;
      end
    end
    // debounce: the synced value lags the pin by two samples; accept after DB equal samples
    for (int k = 0; k < 2; k++) begin
      m_hist[i][k] = {m_hist[i][k][6:0], bi[k]};
      win = m_hist[i][k][DB+1:2];
      m_pend[i][k] = 1'b0;
      if (win == '1 && !m_stab[i][k]) begin
        m_stab[i][k] = 1'b1;
        m_pend[i][k] = 1'b1;
      end else if (win == '0 && m_stab[i][k]) begin
        m_stab[i][k] = 1'b0;
      end
    end
    m_t[i]++;
    e_mode[i] = 4'(1 << m_level[i]);
  endtask

  // One clock: advance the model with the values present at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    model_step(0, btn, rst_n);
    model_step(1, btn_s, rst_n);
    #1;
    check("model_main", {mode_m, r_m, g_m, b_m}, {e_mode[0], e_r[0], e_g[0], e_b[0]});
    check("model_small", {mode_s, r_s, g_s, b_s},
          {e_mode[1][1:0], e_r[1][1:0], e_g[1][1:0], e_b[1][1:0]});
  endtask

  // ---------------- button vector table ----------------
  typedef struct {
    logic [1:0] b;
    int         hold;
    logic [3:0] exp_m;
    logic [3:0] exp_w;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int cr, cg, k, hold;

    vecs[0]  = '{2'b01, 20, 4'b1000, 4'b1000};
    vecs[1]  = '{2'b01, 20, 4'b1000, 4'b0001};
    vecs[2]  = '{2'b10, 20, 4'b0100, 4'b1000};
    vecs[3]  = '{2'b10, 20, 4'b0010, 4'b0100};
    vecs[4]  = '{2'b10, 20, 4'b0001, 4'b0010};
    vecs[5]  = '{2'b10, 20, 4'b0001, 4'b0001};
    vecs[6]  = '{2'b11, 20, 4'b0001, 4'b0001};
    vecs[7]  = '{2'b01,  2, 4'b0001, 4'b0001};
    vecs[8]  = '{2'b01,  3, 4'b0001, 4'b0001};
    vecs[9]  = '{2'b01,  4, 4'b0010, 4'b0010};
    vecs[10] = '{2'b01,  5, 4'b0100, 4'b0100};

    // reset for three clocks
    rst_n = 1'b0; btn = 2'b00; btn_s = 2'b00;
    repeat (3) cycle();
    check("reset_mode_main", mode_m, 4'b0100);
    check("reset_mode_wrap", mode_w, 4'b0100);
    check("reset_mode_small", mode_s, 2'b10);
    check("reset_leds", {r_m, g_m, b_m, r_w, g_w, b_w, r_s, g_s, b_s}, 0);
    rst_n = 1'b1;

    // envelope ramp: small instance duty per 8-clock period, main hue rotation
    cr = 0; cg = 0;
    for (int n = 0; n < 520; n++) begin
      cycle();
      if (n < 168) begin
        cr += int'(r_s[0] === 1'b1);
        cg += int'(g_s[0] === 1'b1);
        if (n % 8 == 7) begin
          k = n / 8;
          check("small_duty_r", cr, tri_val(k, 7));
          check("small_duty_g", cg, (k >= 16) ? tri_val(k, 7) : 0);
          cr = 0; cg = 0;
        end
      end
      if (n == 511) check("main_dark_before_step", {r_m, g_m, b_m}, 0);
      if (n == 512) begin
        check("main_red_ch0", r_m, 3'b001);
        check("main_green_ch1", g_m, 3'b010);
        check("main_blue_ch2", b_m, 3'b100);
      end
    end

    // speed buttons: presses, saturation, wrap, simultaneous and glitches
    for (int v = 0; v < 11; v++) begin
      btn = vecs[v].b;
      repeat (vecs[v].hold) cycle();
      btn = 2'b00;
      repeat (20) cycle();
      check($sformatf("vec%0d_mode_main", v), mode_m, vecs[v].exp_m);
      check($sformatf("vec%0d_mode_wrap", v), mode_w, vecs[v].exp_w);
    end

    // exact latency from a clean rising edge to led_mode
    btn = 2'b01;
    for (int j = 1; j <= DB + 3; j++) begin
      cycle();
      if (j == DB + 2) check("latency_before", mode_m, 4'b0100);
      if (j == DB + 3) check("latency_at", mode_m, 4'b1000);
    end
    btn = 2'b00;
    repeat (20) cycle();

    // randomized buttons on both model instances, with a reset mid-run
    for (int it = 0; it < 250; it++) begin
      btn   = 2'($urandom_range(0, 3));
      btn_s = 2'($urandom_range(0, 3));
      hold  = $urandom_range(1, 12);
      repeat (hold) cycle();
      if (it == 120) begin
        rst_n = 1'b0;
        cycle();
        check("midrst_leds", {r_m, g_m, b_m, r_w, g_w, b_w, r_s, g_s, b_s}, 0);
        check("midrst_mode_main", mode_m, 4'b0100);
        check("midrst_mode_wrap", mode_w, 4'b0100);
        check("midrst_mode_small", mode_s, 2'b10);
        rst_n = 1'b1;
      end
    end
    btn = 2'b00; btn_s = 2'b00;
    repeat (20) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rainbow_breathing_pwm_multi.md
Name: rainbow_breathing_pwm_multi

Overview:
Parametrised successor to the single-RGB adjustable rainbow breathing LED. It drives NUM_CH RGB LEDs from one shared breathing envelope, with a per-channel hue phase offset. The speed level is set through debounced up/down buttons and shown as a one-hot led_mode. It sits directly behind board buttons and in front of the RGB LED pins.

Parameters:
NUM_CH, 2, number of RGB LED channels
PWM_BITS, 8, PWM counter/brightness width; PWM period = 2^PWM_BITS clocks
NUM_SPEEDS, 4, number of speed levels; led_mode width
RESET_SPEED, 2, speed level after reset (one-hot 0100 at default)
DEBOUNCE_CYCLES, 4, consecutive stable synced cycles needed to accept a button change
WRAP, 0, 0 = saturate at min/max speed; 1 = wrap around
HUE_OFFSET, 2, hue index offset between adjacent channels (mod 6)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
btn  in  2  btn[0] speed up, btn[1] speed down; asynchronous, bouncy
led_mode  out  NUM_SPEEDS  one-hot current speed level
led_r  out  NUM_CH  red PWM per channel
led_g  out  NUM_CH  green PWM per channel
led_b  out  NUM_CH  blue PWM per channel

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - level=RESET_SPEED, led_mode=1<<RESET_SPEED.
  - pwm_cnt=0, brightness=0, dir=up, hue=0, step_cnt=0.
  - Debouncer stable states=0.
  - All led_* outputs 0 during reset and in the first cycle after release.
  - Reset mid-operation returns everything to these values on the next edge.
- Button path (per bit, in btn_debounce):
  - 2-FF synchroniser, then a counter. The stable value takes the synced value after it differs for DEBOUNCE_CYCLES consecutive cycles; any mismatch clears the counter.
  - A one-cycle pulse is generated on the stable rising edge.
  - led_mode changes exactly DEBOUNCE_CYCLES+3 clocks after a clean btn rising edge.
  - Releases and bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- Speed update on pulses:
  - up only: level+1.
  - down only: level-1.
  - both pulses in the same cycle: no change.
  - At level NUM_SPEEDS-1 with up: hold if WRAP=0, go to 0 if WRAP=1. Down at 0 is symmetric.
  - Level 0 is the slowest. led_mode is always exactly one-hot.
- PWM: pwm_cnt free-runs 0..2^PWM_BITS-1 and wraps. A period tick asserts when pwm_cnt = max.
- Breathing envelope:
  - step_cnt counts period ticks. When step_cnt = (1<<(NUM_SPEEDS-1-level))-1, step_cnt returns to 0 and brightness steps by 1.
  - Up: brightness increments until max, then dir flips to down, and brightness holds max for that step.
  - Down: brightness decrements until 0, then dir flips to up and hue advances (mod 6).
  - A level change clears step_cnt in the same cycle.
- Hue table (R,G,B on-mask), index 0..5: 100, 110, 010, 011, 001, 101.
- Channel outputs: channel c uses hue index (hue + c*HUE_OFFSET) mod 6.
  - led_x[c] = mask_x & (pwm_cnt < brightness), registered, so outputs lag the counter by 1 clock.
  - brightness=0 gives a constant low output.
  - brightness=max gives high for 2^PWM_BITS-1 of every 2^PWM_BITS clocks.
- All arithmetic is unsigned. The level register is clog2(NUM_SPEEDS) bits; the step counter is NUM_SPEEDS bits.

Decomposition:
- Package rainbow_pkg holds:
  - HUE_COUNT=6;
  - the 6-entry 3-bit hue mask table as a constant function;
  - the dir enum (DIR_UP, DIR_DOWN);
  - the clog2 helper.
- Sub-module btn_debounce (synchroniser + counter + rising-edge pulse), parameter DEBOUNCE_CYCLES, instantiated twice.

Test Plan:
- Reset with rst_n=0 for 3 clocks, then release -> led_mode=0100; led_r/g/b=0 until brightness>0.
- btn=01 held 20 clocks, then released; repeat -> led_mode 0100→1000→1000 with WRAP=0; with WRAP=1 the second press gives 0001. Change lands exactly DEBOUNCE_CYCLES+3 clocks after the edge.
- btn=10 twice from 0100 -> 0010, then 0001; a third press with WRAP=0 stays 0001.
- btn=11 rising in the same cycle -> led_mode unchanged. A 2-clock glitch on btn[0] with DEBOUNCE_CYCLES=4 -> unchanged.
- PWM_BITS=3, NUM_SPEEDS=2, level 1 -> brightness 0..7..0 with one step per 8 clocks. led_r[0] duty equals brightness/8 each period. Hue goes 0→1 at the first return to 0 and led_g[0] starts toggling.
- NUM_CH=3, HUE_OFFSET=2, hue=0 -> ch0 red only, ch1 green only, ch2 blue only. Assert rst_n=0 mid-ramp -> all outputs 0 and led_mode=0100 on the next edge.
